// File: rtl/div_arb.sv
// div_arb: round-robin sharing of one iterative 16-bit divider among NREQ requesters.
// Optional: DIVARB_DIVZERO_EN answers zero divisors directly with 16'hFFFF/err, no divider issue.
module div_arb #(
  parameter int NREQ    = 4,
  parameter int DIV_LAT = 17,
  parameter int TMO     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_v,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    req_rdy,
  output logic [NREQ-1:0]    rsp_v,
  output logic [15:0]        rsp_q,
  output logic               rsp_err,
  output logic               busy,
  output logic [15:0]        div_a,
  output logic [15:0]        div_b,
  output logic               div_iv,
  input  logic [15:0]        div_q,
  input  logic               div_ov
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(DIV_LAT + TMO);
  localparam logic [CW-1:0] CNT_OK  = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] CNT_TMO = CW'(DIV_LAT - 1 + TMO);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;

  logic           found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] idx;
  logic [15:0]    sel_a;
  logic [15:0]    sel_b;

  // First asserted request at or above ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_v[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (state == IDLE && found) req_rdy[grant_id] = 1'b1;
  end

  assign busy   = (state != IDLE);
  assign div_iv = (state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      id      <= '0;
      cnt     <= '0;
      div_a   <= '0;
      div_b   <= '0;
      rsp_v   <= '0;
      rsp_q   <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_v <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            id    <= grant_id;
            div_a <= sel_a;
            div_b <= sel_b;
`ifdef DIVARB_DIVZERO_EN
            if (sel_b == 16'd0) begin
              rsp_v[grant_id] <= 1'b1;
              rsp_q           <= 16'hFFFF;
              rsp_err         <= 1'b1;
              state           <= RESP;
            end else begin
              state <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Only an ov landing exactly at the expected latency is trusted.
          if (div_ov && cnt == CNT_OK) begin
            rsp_v[id] <= 1'b1;
            rsp_q     <= div_q;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else if (cnt == CNT_TMO) begin
            rsp_v[id] <= 1'b1;
            rsp_q     <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ptr   <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arb.sv
// Directed bench for div_arb with a fixed-latency divider model that is never reset.
module tb_div_arb;
  localparam int NREQ    = 4;
  localparam int DIV_LAT = 17;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_v;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_rdy;
  logic [NREQ-1:0]    rsp_v;
  logic [15:0]        rsp_q;
  logic               rsp_err;
  logic               busy;
  logic [15:0]        div_a;
  logic [15:0]        div_b;
  logic               div_iv;
  logic [15:0]        div_q;
  logic               div_ov;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic model_en = 1'b1;

  div_arb dut (
    .clk(clk), .rst_n(rst_n), .req_v(req_v), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .rsp_v(rsp_v), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy),
    .div_a(div_a), .div_b(div_b), .div_iv(div_iv), .div_q(div_q), .div_ov(div_ov)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: result pops out DIV_LAT clocks after the iv cycle.
  logic [DIV_LAT-1:0] pv = '0;
  logic [15:0]        pq [DIV_LAT];
  always @(posedge clk) begin
    pv    <= {pv[DIV_LAT-2:0], div_iv & model_en};
    pq[0] <= (div_b == 16'd0) ? 16'hFFFF : div_a / div_b;
    for (int i = 1; i < DIV_LAT; i++) pq[i] <= pq[i-1];
  end
  assign div_ov = pv[DIV_LAT-1];
  assign div_q  = pq[DIV_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_v = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated request; latency counted in cycles after the accept cycle T0.
  task automatic do_op(input string tag, input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic ee, input int elat, input int eiv);
    int lat;
    int ivs;
    @(posedge clk);
    #1;
    req_v[id]          = 1'b1;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(req_rdy), 32'(1 << id));
    @(posedge clk);
    #1 req_v[id] = 1'b0;
    lat = 0;
    ivs = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (div_iv) ivs++;
      if (rsp_v != '0) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_iv"}, 32'(ivs), 32'(eiv));
    check({tag, "_rspv"}, 32'(rsp_v), 32'(1 << id));
    check({tag, "_q"}, 32'(rsp_q), 32'(eq));
    check({tag, "_err"}, 32'(rsp_err), 32'(ee));
  endtask

  initial begin
    int t0, prev, k, r1, y1, seen0;
    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    req_v = '0;
    @(negedge clk);
    check("rst_rdy", 32'(req_rdy), 0);
    check("rst_rspv", 32'(rsp_v), 0);
    check("rst_q", 32'(rsp_q), 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_iv", 32'(div_iv), 0);
    check("rst_ab", {div_a, div_b}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_op("single", 0, 16'd100, 16'd7, 16'd14, 1'b0, 19, 1);

    // Fairness: everyone requests continuously.
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'(1000 * (i + 1));
      req_b[16*i +: 16] = 16'd10;
    end
    req_v = '1;
    t0 = cyc;
    prev = 0;
    k = 0;
    for (int n = 0; n < 140 && k < 5; n++) begin
      @(negedge clk);
      if (rsp_v != '0) begin
        check("fair_who", 32'(rsp_v), 32'(1 << (k % 4)));
        check("fair_q", 32'(rsp_q), 32'(100 * (k % 4 + 1)));
        check("fair_gap", 32'(cyc - ((k == 0) ? t0 : prev)), (k == 0) ? 32'd19 : 32'd20);
        prev = cyc;
        k++;
        if (k == 5) req_v = '0;
      end
    end
    check("fair_count", 32'(k), 5);
    req_v = '0;

    do_reset();
`ifdef DIVARB_DIVZERO_EN
    do_op("zero", 2, 16'd5, 16'd0, 16'hFFFF, 1'b1, 1, 0);
`else
    do_op("zero", 2, 16'd5, 16'd0, 16'hFFFF, 1'b0, 19, 1);
`endif

    do_reset();
    model_en = 1'b0;
    do_op("tmo", 3, 16'd20, 16'd4, 16'd0, 1'b1, 22, 1);
    model_en = 1'b1;
    do_op("after_tmo", 0, 16'd81, 16'd9, 16'd9, 1'b0, 19, 1);

    // Reset in WAIT; the aborted op's ov arrives during the next op's WAIT.
    do_reset();
    @(posedge clk);
    #1;
    req_v[0]       = 1'b1;
    req_a[15:0]    = 16'd9;
    req_b[15:0]    = 16'd3;
    @(negedge clk);
    check("abort_rdy", 32'(req_rdy), 1);
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_rspv", 32'(rsp_v), 0);
    check("abort_ab", {div_a, div_b}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_op("post_abort", 0, 16'd50, 16'd5, 16'd10, 1'b0, 19, 1);

    // Withdrawal: requester 1 gives up while requester 0 is served.
    do_reset();
    @(posedge clk);
    #1;
    req_v          = 4'b0011;
    req_a[31:0]    = {16'd60, 16'd60};
    req_b[31:0]    = {16'd6, 16'd6};
    @(negedge clk);
    check("wd_rdy", 32'(req_rdy), 1);
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    r1 = 0;
    y1 = 0;
    seen0 = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 5) req_v[1] = 1'b0;
      if (rsp_v[1]) r1++;
      if (req_rdy[1]) y1++;
      if (rsp_v[0]) begin
        seen0++;
        check("wd_q", 32'(rsp_q), 10);
      end
    end
    check("wd_rsp0", 32'(seen0), 1);
    check("wd_rsp1", 32'(r1), 0);
    check("wd_rdy1", 32'(y1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
